// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS main control FSM with memory-ready stalls.
// Optional bne support via MIPS_CTRL_BNE_EN. Rev 1.0
`default_nettype none

module mips_mc_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_BNE   = 6'b000101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bne_q, bne_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bne_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bne_q     <= bne_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    illegal_d     = illegal_q;
    bne_d         = bne_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        bne_d     = 1'b0;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          state_d = S_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
        end else if (opcode == OP_BNE) begin
          state_d = S_BRANCH;
          bne_d   = 1'b1;
`else
        end else if (opcode == OP_BNE) begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
`endif
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = bne_q;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must suppress the FETCH-state Mealy enables immediately
    if (!rst_n) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

`default_nettype wire

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM.
- Sits directly upstream of the enabled datapath registers (IR, PC, MDR, A/B, ALUOut) and the register file.
- Decodes the instruction opcode and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Generates the write enables (ir_write, pc_write, reg_write, mem_write) and the datapath mux selects for each cycle.
- Stalls on a memory-ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode
- OP_BNE, 6'b000101, branch-not-equal opcode (used only with the optional feature)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] taken from the IR output
- mem_ready  in  1  memory has completed the current read/write this cycle
- ir_write  out  1  IR enable
- pc_write  out  1  unconditional PC enable
- pc_write_cond  out  1  conditional PC enable; ANDed with the zero flag in the datapath
- branch_ne  out  1  invert the zero flag for the branch condition
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_to_reg  out  1  writeback data select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination register select: 0=rt, 1=rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0=PC, 1=A
- alu_src_b  out  2  ALU B select: 00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2
- alu_op  out  2  ALU operation class: 00=add, 01=sub, 10=funct field
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky flag: an unknown opcode was decoded

Behaviour:
- Reset is asynchronous active-low (rst_n). While rst_n=0:
  - state=FETCH(0) and illegal=0.
  - pc_write, pc_write_cond, ir_write, reg_write and mem_write are forced to 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge.
- Default for every output not listed in a state below is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready. These two are Mealy outputs gated by mem_ready.
  - Transition: stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP.
  - Any other opcode → FETCH, and illegal is set at that edge. illegal holds until reset.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: MEMRD if opcode=lw, otherwise MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Wait here until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write=1, i_or_d=1. mem_write stays asserted until mem_ready=1, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- Latency with mem_ready tied high (each count includes FETCH):
  - lw = 5 cycles; sw, R-type and addi = 4 cycles; beq and j = 3 cycles.
- Timing contract: opcode is sampled only in DECODE and MEMADR. It must come from the IR, which is written only in FETCH.
- Reset asserted mid-instruction: returns to FETCH immediately, with no further write pulse.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- When defined:
  - opcode=OP_BNE in DECODE → BRANCH.
  - branch_ne=1 throughout BRANCH for that instruction.
- When undefined:
  - OP_BNE is treated as illegal: DECODE → FETCH and illegal is set.
  - branch_ne is tied to 0.

Test Plan:
- Reset: hold rst_n=0 with mem_ready=1 → state=0, ir_write=pc_write=reg_write=mem_write=0, illegal=0. Release → ir_write=pc_write=1 on the first cycle.
- lw with mem_ready=1 → states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH → state stays 0 and ir_write stays 0. On mem_ready=1, ir_write pulses for one cycle and the next state is 1.
- sw with mem_ready low for 2 cycles in MEMWR → mem_write=1 for 3 cycles, then state=0.
- R-type → states 0,1,6,7,0, with alu_op=10 in state 6 and reg_dst=1 in state 7. j → states 0,1,11,0, with pc_source=10.
- Opcode 6'b111111 → DECODE→FETCH and illegal=1 from the next cycle. Opcode 6'b000101 → BRANCH with branch_ne=1 if MIPS_CTRL_BNE_EN is defined, otherwise illegal=1.
